// File: rtl/abro_pkg.sv
// Shared types for the ABRO event driver: FSM states, sequence modes and event helpers.
package abro_pkg;

   localparam int TIMEOUT_DEFAULT = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GAP_1,
      ST_FIRE_1,
      ST_GAP_2,
      ST_FIRE_2,
      ST_WAIT_O,
      ST_REPORT
   } state_t;

   typedef enum logic [1:0] {
      MODE_AB     = 2'b00,
      MODE_BA     = 2'b01,
      MODE_BOTH   = 2'b10,
      MODE_A_ONLY = 2'b11
   } mode_t;

   function automatic logic fire1_a(input mode_t m);
      return m != MODE_BA;
   endfunction

   function automatic logic fire1_b(input mode_t m);
      return (m == MODE_BA) || (m == MODE_BOTH);
   endfunction

   function automatic logic two_events(input mode_t m);
      return (m == MODE_AB) || (m == MODE_BA);
   endfunction

endpackage

// File: rtl/abro_event_driver_if.sv
// Request/result bundle between the sequence controller and the driver.
interface abro_event_driver_if #(
   parameter int GAP_W = 4
);
   logic             start;
   logic [1:0]       mode;
   logic [GAP_W-1:0] gap;
   logic             o;
   logic             a;
   logic             b;
   logic             busy;
   logic             done;
   logic             pass;

   modport master (output start, mode, gap, o, input a, b, busy, done, pass);
   modport slave  (input start, mode, gap, o, output a, b, busy, done, pass);
endinterface

// File: rtl/abro_cycle_counter.sv
// Loadable down-counter that saturates at zero; zero flag is combinational from the count.
module abro_cycle_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] val,
   output logic         zero
);
   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= val;
      else if (dec && count != '0)
         count <= count - W'(1);
   end

   assign zero = (count == '0);
endmodule

// File: rtl/abro_event_driver.sv
// Drives one A/B event sequence into an ABRO machine and checks its o response.
// Events land at start+1+gap and start+2+2*gap; start is ignored unless idle.
module abro_event_driver
   import abro_pkg::*;
#(
   parameter int GAP_W   = 4,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   abro_event_driver_if.slave bus
);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam int CNT_W = (GAP_W > TO_W) ? GAP_W : TO_W;

   state_t           state;
   mode_t            mode_q;
   mode_t            mode_in;
   logic [GAP_W-1:0] gap_q;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_val;

   assign mode_in = mode_t'(bus.mode);

   // Counter is loaded with length-1 so that zero marks the last cycle of a phase.
   always_comb begin
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = '0;
      case (state)
         ST_IDLE: begin
            cnt_load = bus.start && (bus.gap != '0);
            cnt_val  = CNT_W'(bus.gap) - CNT_W'(1);
         end
         ST_FIRE_1: begin
            cnt_load = 1'b1;
            cnt_val  = (two_events(mode_q) && gap_q != '0) ? CNT_W'(gap_q) - CNT_W'(1)
                                                           : CNT_W'(TIMEOUT - 1);
         end
         ST_FIRE_2: begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(TIMEOUT - 1);
         end
         ST_GAP_1, ST_GAP_2, ST_WAIT_O: cnt_dec = 1'b1;
         default: ;
      endcase
   end

   abro_cycle_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .dec   (cnt_dec),
      .val   (cnt_val),
      .zero  (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         mode_q   <= MODE_AB;
         gap_q    <= '0;
         bus.a    <= 1'b0;
         bus.b    <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.pass <= 1'b0;
      end else begin
         bus.a    <= 1'b0;
         bus.b    <= 1'b0;
         bus.done <= 1'b0;
         case (state)
            ST_IDLE: begin
               bus.busy <= 1'b0;
               if (bus.start) begin
                  mode_q   <= mode_in;
                  gap_q    <= bus.gap;
                  bus.busy <= 1'b1;
                  bus.pass <= 1'b0;
                  if (bus.gap == '0) begin
                     state <= ST_FIRE_1;
                     bus.a <= fire1_a(mode_in);
                     bus.b <= fire1_b(mode_in);
                  end else begin
                     state <= ST_GAP_1;
                  end
               end
            end
            ST_GAP_1: begin
               if (bus.o) begin
                  state    <= ST_REPORT;
                  bus.done <= 1'b1;
               end else if (cnt_zero) begin
                  state <= ST_FIRE_1;
                  bus.a <= fire1_a(mode_q);
                  bus.b <= fire1_b(mode_q);
               end
            end
            ST_FIRE_1: begin
               if (bus.o) begin
                  state    <= ST_REPORT;
                  bus.done <= 1'b1;
               end else if (!two_events(mode_q)) begin
                  state <= ST_WAIT_O;
               end else if (gap_q == '0) begin
                  state <= ST_FIRE_2;
                  bus.a <= (mode_q == MODE_BA);
                  bus.b <= (mode_q == MODE_AB);
               end else begin
                  state <= ST_GAP_2;
               end
            end
            ST_GAP_2: begin
               if (bus.o) begin
                  state    <= ST_REPORT;
                  bus.done <= 1'b1;
               end else if (cnt_zero) begin
                  state <= ST_FIRE_2;
                  bus.a <= (mode_q == MODE_BA);
                  bus.b <= (mode_q == MODE_AB);
               end
            end
            ST_FIRE_2: begin
               if (bus.o) begin
                  state    <= ST_REPORT;
                  bus.done <= 1'b1;
               end else begin
                  state <= ST_WAIT_O;
               end
            end
            ST_WAIT_O: begin
               // A-only expects the machine to stay silent; the others expect o.
               if (bus.o) begin
                  state    <= ST_REPORT;
                  bus.done <= 1'b1;
                  bus.pass <= (mode_q != MODE_A_ONLY);
               end else if (cnt_zero) begin
                  state    <= ST_REPORT;
                  bus.done <= 1'b1;
                  bus.pass <= (mode_q == MODE_A_ONLY);
               end
            end
            ST_REPORT: begin
               state    <= ST_IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/abro_event_driver.md
ABRO_EVENT_DRIVER -- requirements
Module: abro_event_driver

Interface
REQ-001 Parameter GAP_W, default 4, width of the inter-event gap field.
REQ-002 Parameter TIMEOUT, default 8, maximum cycles to wait for o after the final event.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to run one sequence; sampled only in IDLE.
REQ-006 mode  input  2  sequence: 00 A-then-B, 01 B-then-A, 10 A+B same cycle, 11 A only.
REQ-007 gap  input  GAP_W  idle cycles inserted before each event.
REQ-008 o  input  1  ABRO output being checked, sampled each cycle.
REQ-009 a  output  1  A event to the ABRO machine, registered.
REQ-010 b  output  1  B event to the ABRO machine, registered.
REQ-011 busy  output  1  high from the cycle after start is accepted until REPORT completes.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 pass  output  1  result, valid when done=1 and held until the next accepted start.

Function
REQ-014 States SHALL be IDLE, GAP_1, FIRE_1, GAP_2, FIRE_2, WAIT_O and REPORT.
REQ-015 In IDLE with start=1, mode and gap SHALL be latched, and the FSM SHALL go to GAP_1, or to FIRE_1 if gap=0.
REQ-016 GAP_1/GAP_2 SHALL last exactly gap cycles, counted down from the latched gap.
REQ-017 FIRE_1 SHALL last one cycle, with a=1 for modes 00/10/11, b=1 for modes 01/10, and both for mode 10.
REQ-018 FIRE_2 SHALL last one cycle, with b=1 for mode 00 and a=1 for mode 01.
REQ-019 Modes 10 and 11 SHALL skip GAP_2/FIRE_2 and go FIRE_1 -> WAIT_O.
REQ-020 Event cycle SHALL equal start cycle + 1 + gap for FIRE_1, and + 2 + 2*gap for FIRE_2.
REQ-021 a and b SHALL be 0 in every state except FIRE_1/FIRE_2.
REQ-022 WAIT_O SHALL count up to TIMEOUT cycles, starting the cycle after the final fire.
REQ-023 Modes 00/01/10: o=1 in WAIT_O SHALL give pass=1; TIMEOUT expiry without o SHALL give pass=0.
REQ-024 Mode 11: o=1 in WAIT_O SHALL give pass=0; TIMEOUT expiry without o SHALL give pass=1.
REQ-025 o=1 in GAP_1, FIRE_1, GAP_2 or FIRE_2 (early output) SHALL go directly to REPORT with pass=0.
REQ-026 REPORT SHALL assert done for one cycle, then return to IDLE; busy SHALL drop in that IDLE cycle.
REQ-027 start SHALL be ignored when not in IDLE; a start coincident with the REPORT cycle SHALL be dropped.
REQ-028 The counter SHALL be max(GAP_W, clog2(TIMEOUT+1)) bits and SHALL not wrap: it saturates at 0 and terminates at TIMEOUT.

Reset
REQ-029 reset=1 SHALL force IDLE, with a=0, b=0, busy=0, done=0, pass=0 and the counter at 0, on the next clock edge.
REQ-030 reset mid-sequence SHALL abort without a done pulse; reset SHALL take priority over start in the same cycle.

Structure
REQ-031 A shared package abro_pkg SHALL hold the state enum, the mode encodings (MODE_AB, MODE_BA, MODE_BOTH, MODE_A_ONLY) and the TIMEOUT default.
REQ-032 Gap and timeout counting SHALL use one sub-module, abro_cycle_counter (load, decrement, zero flag).

Verification
REQ-033 Mode 00, gap=2, start at cycle 0, o pulsed 2 cycles after b: a=1 at cycle 3, b=1 at cycle 6, then done with pass=1.
REQ-034 Mode 01, gap=0: b at cycle 1, a at cycle 2; o held 0 for 8 cycles -> done at WAIT_O+8 with pass=0.
REQ-035 Mode 10, gap=1: a=b=1 together at cycle 2 only; o=1 at cycle 4 -> pass=1.
REQ-036 Mode 11, gap=3, o held 0 -> only a pulses, at cycle 4; pass=1 after timeout. Repeat with o=1 in WAIT_O -> pass=0.
REQ-037 Mode 00, gap=4, o=1 during GAP_2 -> immediate REPORT, pass=0, and b never asserted.
REQ-038 Mode 00, gap=5, reset at cycle 4 -> a=b=busy=0 at cycle 5 with no done. A start issued while busy -> ignored, sequence timing unchanged.
